// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the main-memory block mover: memory geometry,
//   operation encoding and the mover's FSM state encoding.
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam int ADDR_W = 12;   // memory address width, addresses wrap
   localparam int DATA_W = 16;   // memory word width
   localparam int LEN_W  = 12;   // transfer length width, in words

   typedef enum logic {
      OP_COPY = 1'b0,
      OP_FILL = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_block_mover.sv
// ---------------------------------------------------------------------------
// mem_block_mover
//   Bus initiator for the single-port 4096x16 main memory. Performs block
//   COPY (src -> dst, ascending, addresses wrap) and block FILL
//   (constant -> dst) of 0..4095 words while the CPU is halted.
//
// Ports
//   clk            system clock; memory writes on its rising edge
//   reset          asynchronous, active-high reset
//   start          request pulse, sampled only in IDLE
//   op             0 = COPY, 1 = FILL
//   src_addr       COPY source base
//   dst_addr       destination base
//   length         word count, 0 = no transfer
//   fill_value     FILL word
//   busy           high from the cycle after start accept until done
//   done           one-cycle completion pulse
//   mem_address    memory Address
//   mem_data       memory DATA
//   mem_w_enable   memory w_enable
//   mem_read_data  memory read_data, combinational on mem_address
//   dbg_state      current FSM state, for observation only
//   checksum       (MEM_MOVER_CHECKSUM_EN only) sum of written words
//
// Handshake: a request is accepted on any rising edge where start=1 and the
//   FSM is in IDLE; start at any other time is dropped, nothing is queued.
//   Completion is signalled by exactly one done cycle, with busy low.
//
// Configuration: define MEM_MOVER_CHECKSUM_EN to add the checksum output.
// ---------------------------------------------------------------------------
module mem_block_mover
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_w_enable,
   input  logic [DATA_W-1:0] mem_read_data,
   output state_e            dbg_state
`ifdef MEM_MOVER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
`ifdef MEM_MOVER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      we_d    = 1'b0;
`ifdef MEM_MOVER_CHECKSUM_EN
      csum_d  = csum_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = op_e'(op);
               src_d  = src_addr;
               dst_d  = dst_addr;
               cnt_d  = length;
               fill_d = fill_value;
`ifdef MEM_MOVER_CHECKSUM_EN
               csum_d = '0;
`endif
               if (length == '0)          state_d = DONE;
               else if (op_e'(op) == OP_COPY) state_d = READ;
               else                       state_d = WRITE;
            end
         end
         READ: begin
            // mem_address already holds the source pointer this cycle
            buf_d   = mem_read_data;
            state_d = WRITE;
         end
         WRITE: begin
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            cnt_d = cnt_q - LEN_W'(1);
`ifdef MEM_MOVER_CHECKSUM_EN
            csum_d = csum_q + data_q;
`endif
            if (cnt_q == LEN_W'(1))  state_d = DONE;
            else if (op_q == OP_COPY) state_d = READ;
            else                      state_d = WRITE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered and
      // line up with the state they describe.
      unique case (state_d)
         READ: begin
            busy_d = 1'b1;
            addr_d = src_d;
         end
         WRITE: begin
            busy_d = 1'b1;
            addr_d = dst_d;
            we_d   = 1'b1;
            data_d = (op_d == OP_FILL) ? fill_d : buf_d;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
`ifdef MEM_MOVER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
`ifdef MEM_MOVER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign mem_address  = addr_q;
   assign mem_data     = data_q;
   assign mem_w_enable = we_q;
   assign dbg_state    = state_q;
`ifdef MEM_MOVER_CHECKSUM_EN
   assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// ---------------------------------------------------------------------------
// tb_mem_block_mover
//   Directed plus randomized checks of mem_block_mover against a word-array
//   memory and a reference image updated with plain loops.
// ---------------------------------------------------------------------------
module tb_mem_block_mover;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              op = 1'b0;
   logic [11:0]       src_addr = '0;
   logic [11:0]       dst_addr = '0;
   logic [11:0]       length = '0;
   logic [15:0]       fill_value = '0;
   logic              busy, done, mem_w_enable;
   logic [11:0]       mem_address;
   logic [15:0]       mem_data, mem_read_data;
   mem_pkg::state_e   dbg_state;
`ifdef MEM_MOVER_CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   logic [15:0] mem [4096];
   logic [15:0] ref_mem [4096];

   int n_asserts = 0;
   int n_fail = 0;

   mem_block_mover dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_value(fill_value), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_data(mem_data),
      .mem_w_enable(mem_w_enable), .mem_read_data(mem_read_data),
      .dbg_state(dbg_state)
`ifdef MEM_MOVER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   // clock / memory model
   always #5 clk = ~clk;
   assign mem_read_data = mem[mem_address];
   always @(posedge clk) if (mem_w_enable) mem[mem_address] <= mem_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model: block semantics straight from the operation definition
   task automatic ref_copy(input logic [11:0] s, input logic [11:0] d, input int n);
      for (int i = 0; i < n; i++) ref_mem[d + 12'(i)] = ref_mem[s + 12'(i)];
   endtask

   task automatic ref_fill(input logic [11:0] d, input int n, input logic [15:0] v);
      for (int i = 0; i < n; i++) ref_mem[d + 12'(i)] = v;
   endtask

   task automatic check_image(input string tag);
      int diffs = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check(tag, 32'(diffs), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_we"},   32'(mem_w_enable), 32'd0);
      check({tag, "_addr"}, 32'(mem_address), 32'd0);
      check({tag, "_data"}, 32'(mem_data), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(mem_pkg::IDLE));
   endtask

   // Launch one request and follow it cycle by cycle. Cycle k is the period
   // after the k-th rising edge, edge 0 being the one that samples start.
   // glitch_at pulses start in that cycle; reset_at asserts reset in that cycle.
   task automatic run_op(input logic o, input logic [11:0] s, input logic [11:0] d,
                         input int n, input logic [15:0] f,
                         input int glitch_at, input int reset_at,
                         output int done_cyc, output int n_wr, output int n_bad);
      int cyc;
      logic exp_we;
      logic [11:0] exp_a;
      @(negedge clk);
      op = o; src_addr = s; dst_addr = d; length = 12'(n); fill_value = f; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; done_cyc = -1; n_wr = 0; n_bad = 0;
      while (done_cyc < 0 && cyc < 20000) begin
         if (reset_at == cyc) begin
            reset = 1'b1;
            #1;
            check_idle_outputs("reset_mid_op");
            done_cyc = 0;
         end else begin
            start = (glitch_at == cyc);
            if (done) begin
               done_cyc = cyc;
               if (busy !== 1'b0 || mem_w_enable !== 1'b0) n_bad++;
            end else begin
               exp_we = o ? 1'b1 : (cyc % 2 == 0);
               if (o)           exp_a = d + 12'(cyc - 1);
               else if (exp_we) exp_a = d + 12'(cyc / 2 - 1);
               else             exp_a = s + 12'((cyc - 1) / 2);
               if (mem_w_enable !== exp_we || busy !== 1'b1 || mem_address !== exp_a) n_bad++;
               if (mem_w_enable) n_wr++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int dc, nw, nb, quiet, n;
      logic o;
      logic [11:0] s, d;
      logic [15:0] f, saved;

      for (int i = 0; i < 4096; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end

      // reset state
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("idle");

      // FILL dst=0x020 len=4
      saved = mem[12'h024];
      run_op(1'b1, 12'h000, 12'h020, 4, 16'hBEEF, 0, 0, dc, nw, nb);
      ref_fill(12'h020, 4, 16'hBEEF);
      check("fill_done_cycle", 32'(dc), 32'd5);
      check("fill_writes", 32'(nw), 32'd4);
      check("fill_pattern", 32'(nb), 32'd0);
      check("fill_last_word", 32'(mem[12'h023]), 32'hBEEF);
      check("fill_next_untouched", 32'(mem[12'h024]), 32'(saved));
      check_image("fill_image");

      // COPY 0x010 -> 0x100 len=8
      run_op(1'b0, 12'h010, 12'h100, 8, 16'h0, 0, 0, dc, nw, nb);
      ref_copy(12'h010, 12'h100, 8);
      check("copy_done_cycle", 32'(dc), 32'd17);
      check("copy_writes", 32'(nw), 32'd8);
      check("copy_alternate", 32'(nb), 32'd0);
      check_image("copy_image");

      // wrap-around FILL
      run_op(1'b1, 12'h000, 12'hFFE, 4, 16'h1234, 0, 0, dc, nw, nb);
      ref_fill(12'hFFE, 4, 16'h1234);
      check("wrap_done_cycle", 32'(dc), 32'd5);
      check("wrap_ffe", 32'(mem[12'hFFE]), 32'h1234);
      check("wrap_fff", 32'(mem[12'hFFF]), 32'h1234);
      check("wrap_000", 32'(mem[12'h000]), 32'h1234);
      check("wrap_001", 32'(mem[12'h001]), 32'h1234);
      check_image("wrap_image");

      // zero length
      run_op(1'b1, 12'h000, 12'h300, 0, 16'hFFFF, 0, 0, dc, nw, nb);
      check("zero_done_cycle", 32'(dc), 32'd1);
      check("zero_writes", 32'(nw), 32'd0);
      check("zero_pattern", 32'(nb), 32'd0);
      check_image("zero_image");

      // start pulsed mid-transfer is ignored
      run_op(1'b0, 12'h200, 12'h380, 6, 16'h0, 5, 0, dc, nw, nb);
      ref_copy(12'h200, 12'h380, 6);
      check("ignored_start_done_cycle", 32'(dc), 32'd13);
      check("ignored_start_pattern", 32'(nb), 32'd0);
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy || mem_w_enable) quiet++;
      end
      check("ignored_start_single_done", 32'(quiet), 32'd0);
      check_image("ignored_start_image");

      // reset while the fourth write of an 8-word COPY is pending
      run_op(1'b0, 12'h040, 12'h400, 8, 16'h0, 0, 8, dc, nw, nb);
      check("reset_prior_writes", 32'(nw), 32'd3);
      @(negedge clk);
      reset = 1'b0;
      ref_copy(12'h040, 12'h400, 3);
      @(negedge clk);
      check_idle_outputs("after_reset");
      check_image("reset_image");
      run_op(1'b0, 12'h040, 12'h400, 8, 16'h0, 0, 0, dc, nw, nb);
      ref_copy(12'h040, 12'h400, 8);
      check("post_reset_done_cycle", 32'(dc), 32'd17);
      check("post_reset_pattern", 32'(nb), 32'd0);
      check_image("post_reset_image");

      // overlapping COPY, destination just above source
      run_op(1'b0, 12'h500, 12'h502, 6, 16'h0, 0, 0, dc, nw, nb);
      ref_copy(12'h500, 12'h502, 6);
      check("overlap_done_cycle", 32'(dc), 32'd13);
      check_image("overlap_image");

      // randomized requests
      for (int t = 0; t < 8; t++) begin
         o = 1'($urandom_range(0, 1));
         s = 12'($urandom);
         d = 12'($urandom);
         n = int'($urandom_range(1, 24));
         f = 16'($urandom);
         run_op(o, s, d, n, f, 0, 0, dc, nw, nb);
         if (o) ref_fill(d, n, f);
         else   ref_copy(s, d, n);
         check("rand_done_cycle", 32'(dc), o ? 32'(n + 1) : 32'(2 * n + 1));
         check("rand_writes", 32'(nw), 32'(n));
         check("rand_pattern", 32'(nb), 32'd0);
         check_image("rand_image");
      end

`ifdef MEM_MOVER_CHECKSUM_EN
      run_op(1'b1, 12'h000, 12'h600, 3, 16'h8001, 0, 0, dc, nw, nb);
      ref_fill(12'h600, 3, 16'h8001);
      check("checksum_fill", 32'(checksum), 32'h8003);
      run_op(1'b0, 12'h600, 12'h700, 1, 16'h0, 0, 0, dc, nw, nb);
      ref_copy(12'h600, 12'h700, 1);
      check("checksum_cleared", 32'(checksum), 32'h8001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
